// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED pattern blocks: pattern-mode encodings,
// FSM state encodings and the seed-pattern helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package led_pkg;

    // Mode_Sel encodings
    localparam logic [1:0] MODE_BLINK = 2'd0;
    localparam logic [1:0] MODE_RUN_L = 2'd1;
    localparam logic [1:0] MODE_RUN_R = 2'd2;
    localparam logic [1:0] MODE_PONG  = 2'd3;

    // FSM state encodings; each non-IDLE state is the mode being displayed
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_BLINK = 3'd1;
    localparam logic [2:0] ST_RUN_L = 3'd2;
    localparam logic [2:0] ST_RUN_R = 3'd3;
    localparam logic [2:0] ST_PONG  = 3'd4;

    // State that displays a given requested mode
    function automatic logic [2:0] mode_state(input logic [1:0] mode);
        logic [2:0] st;
        case (mode)
            MODE_BLINK: st = ST_BLINK;
            MODE_RUN_L: st = ST_RUN_L;
            MODE_RUN_R: st = ST_RUN_R;
            default:    st = ST_PONG;
        endcase
        return st;
    endfunction

    // Bit idx of the seed pattern for a mode on a bank of width w.
    // BLINK: all ones; RUN_R: MSB only; RUN_L and PONG: LSB only.
    function automatic logic seed_bit(input logic [1:0] mode,
                                      input int unsigned idx,
                                      input int unsigned w);
        logic b;
        case (mode)
            MODE_BLINK: b = 1'b1;
            MODE_RUN_R: b = (idx == w - 1);
            default:    b = (idx == 0);
        endcase
        return b;
    endfunction

endpackage

// File: rtl/edge_detect_module.sv
// ---------------------------------------------------------------------------
// edge_detect_module
// Rising-edge detector on a same-domain signal: registers the previous
// value and flags the cycle in which Sig_In is high but was low before.
// Ports:
//   CLK      - system clock
//   RST      - synchronous, active-high reset (previous value cleared)
//   Sig_In   - signal to watch (must already be in the CLK domain)
//   Rise_Out - combinational, high in the first cycle Sig_In is sampled high
// ---------------------------------------------------------------------------
module edge_detect_module (
    input  logic CLK,
    input  logic RST,
    input  logic Sig_In,
    output logic Rise_Out
);

    logic rPrev;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rPrev <= 1'b0;
        end else begin
            rPrev <= Sig_In;
        end
    end

    assign Rise_Out = Sig_In & ~rPrev;

endmodule

// File: rtl/led_pattern_module.sv
// ---------------------------------------------------------------------------
// led_pattern_module
// Drives a parallel LED bank with a selectable pattern, advancing one step
// on every rising edge of the flash-stage square wave.
// Parameters:
//   LED_W     - number of LEDs (2..16)
// Ports:
//   CLK       - system clock (same domain as the flash stage)
//   RST       - synchronous, active-high reset
//   Flash_In  - square wave from the flash stage; rising edge = one step
//   En        - step enable; 0 drops steps (they are not deferred)
//   Mode_Sel  - requested pattern: 0 blink, 1 run-left, 2 run-right, 3 ping-pong
//   LED_Out   - LED drive, active-high
//   Step_Tick - 1-cycle pulse in the cycle LED_Out takes a new value
// ---------------------------------------------------------------------------
module led_pattern_module
    import led_pkg::*;
#(
    parameter int unsigned LED_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Flash_In,
    input  logic             En,
    input  logic [1:0]       Mode_Sel,
    output logic [LED_W-1:0] LED_Out,
    output logic             Step_Tick
);

    logic             flash_rise;
    logic             step;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [2:0]       req_state;
    logic             dir_up;
    logic             dir_up_nxt;
    logic [LED_W-1:0] led_nxt;
    logic [LED_W-1:0] seed;
    logic [LED_W-1:0] shifted;
    logic             tick_nxt;

    edge_detect_module u_flash_edge (
        .CLK      (CLK),
        .RST      (RST),
        .Sig_In   (Flash_In),
        .Rise_Out (flash_rise)
    );

    assign step      = flash_rise & En;
    assign req_state = mode_state(Mode_Sel);

    always_comb begin
        seed = '0;
        for (int unsigned i = 0; i < LED_W; i++) begin
            seed[i] = seed_bit(Mode_Sel, i, LED_W);
        end
    end

    // A step either advances the current pattern (mode unchanged) or loads
    // the seed of the newly requested mode; never both on the same step.
    always_comb begin
        state_nxt  = state;
        led_nxt    = LED_Out;
        dir_up_nxt = dir_up;
        tick_nxt   = 1'b0;
        shifted    = '0;
        if (step) begin
            tick_nxt = 1'b1;
            if (state != req_state) begin
                state_nxt  = req_state;
                led_nxt    = seed;
                dir_up_nxt = 1'b1;
            end else begin
                case (state)
                    ST_BLINK: led_nxt = ~LED_Out;
                    ST_RUN_L: led_nxt = {LED_Out[LED_W-2:0], LED_Out[LED_W-1]};
                    ST_RUN_R: led_nxt = {LED_Out[0], LED_Out[LED_W-1:1]};
                    ST_PONG: begin
                        // Direction flips on the step that reaches an end,
                        // so each endpoint is shown for a single step.
                        if (dir_up) begin
                            shifted = LED_Out << 1;
                            if (shifted[LED_W-1]) begin
                                dir_up_nxt = 1'b0;
                            end
                        end else begin
                            shifted = LED_Out >> 1;
                            if (shifted == LED_W'(1)) begin
                                dir_up_nxt = 1'b1;
                            end
                        end
                        led_nxt = shifted;
                    end
                    default: led_nxt = LED_Out;
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            LED_Out   <= '0;
            Step_Tick <= 1'b0;
            dir_up    <= 1'b1;
        end else begin
            state     <= state_nxt;
            LED_Out   <= led_nxt;
            Step_Tick <= tick_nxt;
            dir_up    <= dir_up_nxt;
        end
    end

endmodule

// File: tb/tb_led_pattern_module.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_module
// Directed, table-driven bench for led_pattern_module (LED_W = 4 and 8).
// ---------------------------------------------------------------------------
module tb_led_pattern_module;

    logic       CLK = 1'b0;
    logic       RST;
    logic       Flash_In;
    logic       En;
    logic [1:0] Mode_Sel;
    logic [3:0] led4;
    logic       tick4;
    logic [7:0] led8;
    logic       tick8;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 CLK = ~CLK;

    led_pattern_module #(.LED_W(4)) dut4 (
        .CLK       (CLK),
        .RST       (RST),
        .Flash_In  (Flash_In),
        .En        (En),
        .Mode_Sel  (Mode_Sel),
        .LED_Out   (led4),
        .Step_Tick (tick4)
    );

    led_pattern_module #(.LED_W(8)) dut8 (
        .CLK       (CLK),
        .RST       (RST),
        .Flash_In  (Flash_In),
        .En        (En),
        .Mode_Sel  (Mode_Sel),
        .LED_Out   (led8),
        .Step_Tick (tick8)
    );

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [3:0] exp_led;
        logic       exp_tick;
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: 10 low cycles, then a rising edge. Samples the
    // outputs just after the edge that follows the rise, and Step_Tick one
    // cycle later; returns at a negedge with Flash_In still high.
    task automatic pulse(input logic en_v, input logic [1:0] m,
                         output logic [3:0] l4, output logic t4, output logic t4_next,
                         output logic [7:0] l8, output logic t8);
        En       = en_v;
        Mode_Sel = m;
        Flash_In = 1'b0;
        repeat (10) @(negedge CLK);
        Flash_In = 1'b1;
        @(posedge CLK); #1;
        l4 = led4;
        t4 = tick4;
        l8 = led8;
        t8 = tick8;
        @(posedge CLK); #1;
        t4_next = tick4;
        repeat (8) @(negedge CLK);
    endtask

    initial begin
        logic [3:0] l4;
        logic       t4;
        logic       t4n;
        logic [7:0] l8;
        logic       t8;
        logic [7:0] exp8;
        int         ticks;

        vecs = '{
            '{1'b1, 2'd1, 4'b0001, 1'b1},
            '{1'b1, 2'd1, 4'b0010, 1'b1},
            '{1'b1, 2'd1, 4'b0100, 1'b1},
            '{1'b1, 2'd1, 4'b1000, 1'b1},
            '{1'b1, 2'd1, 4'b0001, 1'b1},
            '{1'b1, 2'd1, 4'b0010, 1'b1},
            '{1'b1, 2'd1, 4'b0100, 1'b1},
            '{1'b1, 2'd2, 4'b1000, 1'b1},
            '{1'b1, 2'd2, 4'b0100, 1'b1},
            '{1'b1, 2'd0, 4'b1111, 1'b1},
            '{1'b1, 2'd0, 4'b0000, 1'b1},
            '{1'b1, 2'd0, 4'b1111, 1'b1},
            '{1'b1, 2'd3, 4'b0001, 1'b1},
            '{1'b1, 2'd3, 4'b0010, 1'b1},
            '{1'b1, 2'd3, 4'b0100, 1'b1},
            '{1'b1, 2'd3, 4'b1000, 1'b1},
            '{1'b1, 2'd3, 4'b0100, 1'b1},
            '{1'b1, 2'd3, 4'b0010, 1'b1},
            '{1'b1, 2'd3, 4'b0001, 1'b1},
            '{1'b1, 2'd3, 4'b0010, 1'b1},
            '{1'b1, 2'd3, 4'b0100, 1'b1},
            '{1'b0, 2'd3, 4'b0100, 1'b0},
            '{1'b0, 2'd3, 4'b0100, 1'b0},
            '{1'b1, 2'd3, 4'b1000, 1'b1}
        };

        // Reset, then idle with Mode_Sel = RUN_L
        RST      = 1'b1;
        Flash_In = 1'b0;
        En       = 1'b1;
        Mode_Sel = 2'd1;
        repeat (3) @(negedge CLK);
        chk("reset_led", 16'(led4), 16'h0);
        chk("reset_tick", 16'(tick4), 16'h0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        chk("idle_led", 16'(led4), 16'h0);

        // Table: RUN_L, mode changes, BLINK, PONG bounce, enable gating
        for (int i = 0; i < 24; i++) begin
            pulse(vecs[i].en, vecs[i].mode, l4, t4, t4n, l8, t8);
            chk($sformatf("vec%0d_led", i), 16'(l4), 16'(vecs[i].exp_led));
            chk($sformatf("vec%0d_tick", i), 16'(t4), 16'(vecs[i].exp_tick));
            chk($sformatf("vec%0d_tick_clear", i), 16'(t4n), 16'h0);
        end

        // En raised in the middle of a high phase must not create a step
        En       = 1'b0;
        Mode_Sel = 2'd3;
        Flash_In = 1'b0;
        repeat (10) @(negedge CLK);
        Flash_In = 1'b1;
        ticks    = 0;
        repeat (3) begin
            @(posedge CLK); #1;
            if (tick4) ticks++;
        end
        @(negedge CLK);
        En = 1'b1;
        repeat (7) begin
            @(posedge CLK); #1;
            if (tick4) ticks++;
        end
        chk("en_mid_high_ticks", 16'(ticks), 16'h0);
        chk("en_mid_high_led", 16'(led4), 16'h8);
        @(negedge CLK);
        pulse(1'b1, 2'd3, l4, t4, t4n, l8, t8);
        chk("en_resume_led", 16'(l4), 16'h4);
        chk("en_resume_tick", 16'(t4), 16'h1);

        // Reset coincident with a rising edge: reset wins
        Flash_In = 1'b0;
        repeat (10) @(negedge CLK);
        Flash_In = 1'b1;
        RST      = 1'b1;
        @(posedge CLK); #1;
        chk("rst_step_led", 16'(led4), 16'h0);
        chk("rst_step_tick", 16'(tick4), 16'h0);
        @(negedge CLK);
        RST      = 1'b0;
        Flash_In = 1'b0;
        @(posedge CLK); #1;
        chk("rst_after_led", 16'(led4), 16'h0);
        chk("rst_after_tick", 16'(tick4), 16'h0);
        @(negedge CLK);
        pulse(1'b1, 2'd3, l4, t4, t4n, l8, t8);
        chk("rst_seed_led", 16'(l4), 16'h1);
        chk("rst_seed_tick", 16'(t4), 16'h1);
        pulse(1'b1, 2'd3, l4, t4, t4n, l8, t8);
        chk("rst_pong_up_led", 16'(l4), 16'h2);

        // Width check: LED_W = 8 in RUN_R with wrap-around
        RST      = 1'b1;
        Mode_Sel = 2'd2;
        Flash_In = 1'b0;
        repeat (3) @(negedge CLK);
        RST  = 1'b0;
        exp8 = 8'h80;
        for (int i = 0; i < 9; i++) begin
            pulse(1'b1, 2'd2, l4, t4, t4n, l8, t8);
            chk($sformatf("w8_step%0d_led", i), 16'(l8), 16'(exp8));
            chk($sformatf("w8_step%0d_onehot", i), 16'($onehot(l8)), 16'h1);
            chk($sformatf("w8_step%0d_tick", i), 16'(t8), 16'h1);
            exp8 = {exp8[0], exp8[7:1]};
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
